// File: rtl/collide_pkg.sv
// Shared sizing defaults, sweep FSM state encoding and derived-width helpers
// for the collide-detect sweep sequencer.
package collide_pkg;

    localparam int unsigned GRID_W_DEF = 8192;
    localparam int unsigned WORD_W_DEF = 256;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SETTLE,
        SCAN_RD,
        SCAN_WAIT,
        SCAN_OUT,
        FINISH
    } sweep_state_t;

    function automatic int unsigned num_words(input int unsigned grid_w, input int unsigned word_w);
        return grid_w / word_w;
    endfunction

    // A one-word grid still needs a 1-bit index so ports never collapse to zero width.
    function automatic int unsigned addr_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/collide_sweep_ctrl_if.sv
// Sweep control, grid-vector input, accumulator, obstacle RAM and result-stream signals.
// master = sequencer side, slave = surrounding datapath / test environment.
interface collide_sweep_ctrl_if #(
    parameter int unsigned GRID_W = collide_pkg::GRID_W_DEF,
    parameter int unsigned WORD_W = collide_pkg::WORD_W_DEF,
    parameter int unsigned CNT_W  = collide_pkg::CNT_W_DEF
) ();
    localparam int unsigned ADDR_W = collide_pkg::addr_w(collide_pkg::num_words(GRID_W, WORD_W));

    logic              start;
    logic [CNT_W-1:0]  num_grids;
    logic              busy;
    logic              done;
    logic              collide;

    logic              grid_in_valid;
    logic              grid_in_ready;
    logic [GRID_W-1:0] grid_in_data;

    logic              unit_clear;
    logic [GRID_W-1:0] unit_grid;
    logic [GRID_W-1:0] unit_edge;

    logic              obst_rd;
    logic [ADDR_W-1:0] obst_addr;
    logic [WORD_W-1:0] obst_word;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [WORD_W-1:0] out_data;
    logic              out_hit;

    modport master (
        input  start, num_grids, grid_in_valid, grid_in_data, unit_edge, obst_word, out_ready,
        output busy, done, collide, grid_in_ready, unit_clear, unit_grid,
               obst_rd, obst_addr, out_valid, out_idx, out_data, out_hit
    );

    modport slave (
        output start, num_grids, grid_in_valid, grid_in_data, unit_edge, obst_word, out_ready,
        input  busy, done, collide, grid_in_ready, unit_clear, unit_grid,
               obst_rd, obst_addr, out_valid, out_idx, out_data, out_hit
    );

endinterface

// File: rtl/collide_word_scan.sv
// Word slicer + obstacle compare + result holding register for the edge-state scan.
// Latency: slice registered in the read cycle, hit/idx registered one cycle later.
// Backpressure: registers only load on rd_en/cap_en, so results hold while the sink stalls.
module collide_word_scan #(
    parameter int unsigned GRID_W = collide_pkg::GRID_W_DEF,
    parameter int unsigned WORD_W = collide_pkg::WORD_W_DEF,
    localparam int unsigned NUM_WORDS = collide_pkg::num_words(GRID_W, WORD_W),
    localparam int unsigned ADDR_W    = collide_pkg::addr_w(NUM_WORDS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rd_en,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [GRID_W-1:0] unit_edge,
    input  logic [WORD_W-1:0] obst_word,
    output logic [ADDR_W-1:0] out_idx,
    output logic [WORD_W-1:0] out_data,
    output logic              out_hit
);

    logic [NUM_WORDS-1:0][WORD_W-1:0] edge_words;

    assign edge_words = unit_edge;

    // out_data is taken alongside the RAM read so the compare lines up with obst_word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_idx  <= '0;
            out_data <= '0;
            out_hit  <= 1'b0;
        end else begin
            if (rd_en) begin
                out_data <= edge_words[idx];
            end
            if (cap_en) begin
                out_hit <= |(out_data & obst_word);
                out_idx <= idx;
            end
        end
    end

endmodule

// File: rtl/collide_sweep_ctrl.sv
// Sweep sequencer: clear accumulator, feed counted grid vectors, settle, scan vs obstacle map.
// Latency: start->grid_in_ready 2 cycles; last beat->first obst_rd 2 cycles; 3 cycles/word.
// Backpressure: grid_in_ready only in ACCUM; SCAN_OUT holds the result until out_ready.
module collide_sweep_ctrl
    import collide_pkg::*;
#(
    parameter int unsigned GRID_W = GRID_W_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input logic CLK,
    input logic RST,
    collide_sweep_ctrl_if.master bus
);

    localparam int unsigned NUM_WORDS = num_words(GRID_W, WORD_W);
    localparam int unsigned ADDR_W    = addr_w(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    sweep_state_t      state, state_nxt;
    logic [CNT_W-1:0]  remaining, remaining_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              collide_q, collide_nxt;
    logic              beat;

    assign beat = (state == ACCUM) && bus.grid_in_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            idx       <= '0;
            collide_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            idx       <= idx_nxt;
            collide_q <= collide_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        idx_nxt       = idx;
        collide_nxt   = collide_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    remaining_nxt = bus.num_grids;
                    collide_nxt   = 1'b0;
                    state_nxt     = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = (remaining == '0) ? SETTLE : ACCUM;
            end
            ACCUM: begin
                if (beat) begin
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                idx_nxt   = '0;
                state_nxt = SCAN_RD;
            end
            SCAN_RD: begin
                state_nxt = SCAN_WAIT;
            end
            SCAN_WAIT: begin
                state_nxt = SCAN_OUT;
            end
            SCAN_OUT: begin
                if (bus.out_ready) begin
                    collide_nxt = collide_q | bus.out_hit;
                    if (idx == LAST_IDX) begin
                        state_nxt = FINISH;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = SCAN_RD;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The accumulator ORs unit_grid every cycle, so anything but an accepted beat is zero.
    assign bus.unit_grid     = beat ? bus.grid_in_data : '0;
    assign bus.unit_clear    = RST || (state == CLEAR);
    assign bus.grid_in_ready = (state == ACCUM);
    assign bus.busy          = (state != IDLE) && (state != FINISH);
    assign bus.done          = (state == FINISH);
    assign bus.collide       = collide_q;
    assign bus.obst_rd       = (state == SCAN_RD);
    assign bus.obst_addr     = idx;
    assign bus.out_valid     = (state == SCAN_OUT);

    collide_word_scan #(
        .GRID_W (GRID_W),
        .WORD_W (WORD_W)
    ) u_scan (
        .CLK       (CLK),
        .RST       (RST),
        .rd_en     (state == SCAN_RD),
        .cap_en    (state == SCAN_WAIT),
        .idx       (idx),
        .unit_edge (bus.unit_edge),
        .obst_word (bus.obst_word),
        .out_idx   (bus.out_idx),
        .out_data  (bus.out_data),
        .out_hit   (bus.out_hit)
    );

endmodule

// File: tb/tb_collide_sweep_ctrl.sv
// Directed bench for collide_sweep_ctrl with a behavioural OR accumulator and obstacle RAM.
module tb_collide_sweep_ctrl;

    localparam int GW = 8192;
    localparam int WW = 256;
    localparam int NW = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    collide_sweep_ctrl_if bus ();

    collide_sweep_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Environment: OR accumulator and registered-read obstacle RAM.
    logic [GW-1:0] acc;
    logic [WW-1:0] obst_mem [NW];

    assign bus.unit_edge = acc;

    always @(posedge CLK) begin
        if (bus.unit_clear) acc <= '0;
        else                acc <= acc | bus.unit_grid;
        if (bus.obst_rd) bus.obst_word <= obst_mem[bus.obst_addr];
    end

    // Monitor, sampled on the falling edge; per-sweep fields restart on an accepted start.
    int cyc = 0;
    int done_cnt = 0;
    int res_cnt = 0;
    int order_err = 0;
    int beats = 0;
    int start_cyc = 0;
    int first_ready_cyc = -1;
    int first_rd_cyc = -1;
    int last_beat_cyc = 0;
    int done_cyc = 0;
    logic collide_at_done = 1'b0;
    logic [WW-1:0] res_data [NW];
    logic          res_hit  [NW];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST && bus.start && !bus.busy && !bus.done) begin
            start_cyc       <= cyc;
            first_ready_cyc <= -1;
            first_rd_cyc    <= -1;
            res_cnt         <= 0;
            order_err       <= 0;
            beats           <= 0;
        end
        if (bus.grid_in_ready && first_ready_cyc < 0) first_ready_cyc <= cyc;
        if (bus.grid_in_valid && bus.grid_in_ready) begin
            beats         <= beats + 1;
            last_beat_cyc <= cyc;
        end
        if (bus.obst_rd && first_rd_cyc < 0) first_rd_cyc <= cyc;
        if (bus.out_valid && bus.out_ready) begin
            if (int'(bus.out_idx) != res_cnt) order_err <= order_err + 1;
            res_data[bus.out_idx] <= bus.out_data;
            res_hit[bus.out_idx]  <= bus.out_hit;
            res_cnt <= res_cnt + 1;
        end
        if (bus.done) begin
            done_cnt        <= done_cnt + 1;
            done_cyc        <= cyc;
            collide_at_done <= bus.collide;
        end
    end

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        bus.start     = 1'b1;
        bus.num_grids = n;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic send_beat(input logic [GW-1:0] vec, input string tag);
        bit ok;
        ok = 1'b0;
        bus.grid_in_data  = vec;
        bus.grid_in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLK);
            if (bus.grid_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.grid_in_valid = 1'b0;
        check(tag, WW'(ok), WW'(1));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base;
        base = done_cnt;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (done_cnt != base) break;
        end
        repeat (3) tick();
        check(tag, WW'(done_cnt - base), WW'(1));
    endtask

    task automatic check_scan(input logic [GW-1:0] exp_acc, input logic [NW-1:0] exp_hits, input string tag);
        logic [NW-1:0][WW-1:0] ew;
        ew = exp_acc;
        check({tag, "_cnt"}, WW'(res_cnt), WW'(NW));
        check({tag, "_order"}, WW'(order_err), WW'(0));
        for (int i = 0; i < NW; i++) begin
            check($sformatf("%s_data%0d", tag, i), res_data[i], ew[i[4:0]]);
            check($sformatf("%s_hit%0d", tag, i), WW'(res_hit[i]), WW'(exp_hits[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    logic [GW-1:0] v0, v1, v2, vs;
    logic [GW-1:0] d [6];
    logic [5:0]    pat;
    logic [5:0]    exp_rdy;
    logic [WW-1:0] w;
    bit            ok;
    int            base;

    initial begin
        bus.start         = 1'b0;
        bus.num_grids     = '0;
        bus.grid_in_valid = 1'b0;
        bus.grid_in_data  = '0;
        bus.out_ready     = 1'b1;
        for (int i = 0; i < NW; i++) obst_mem[i] = '0;

        v0 = '0; v0[0]    = 1'b1;
        v1 = '0; v1[300]  = 1'b1;
        v2 = '0; v2[8191] = 1'b1;

        // Reset state
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy",      WW'(bus.busy), WW'(0));
        check("rst_done",      WW'(bus.done), WW'(0));
        check("rst_collide",   WW'(bus.collide), WW'(0));
        check("rst_ready",     WW'(bus.grid_in_ready), WW'(0));
        check("rst_obst_rd",   WW'(bus.obst_rd), WW'(0));
        check("rst_obst_addr", WW'(bus.obst_addr), WW'(0));
        check("rst_out_valid", WW'(bus.out_valid), WW'(0));
        check("rst_out_idx",   WW'(bus.out_idx), WW'(0));
        check("rst_out_data",  bus.out_data, WW'(0));
        check("rst_out_hit",   WW'(bus.out_hit), WW'(0));
        check("rst_unit_clear", WW'(bus.unit_clear), WW'(1));
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("idle_unit_clear", WW'(bus.unit_clear), WW'(0));
        tick();

        // Reset after 2 of 5 beats aborts without done
        base = done_cnt;
        pulse_start(16'd5);
        send_beat(v0, "abort_beat0");
        send_beat(v1, "abort_beat1");
        RST = 1'b1;
        @(negedge CLK);
        check("abort_unit_clear", WW'(bus.unit_clear), WW'(1));
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("abort_busy",  WW'(bus.busy), WW'(0));
        check("abort_ready", WW'(bus.grid_in_ready), WW'(0));
        repeat (5) tick();
        check("abort_no_done", WW'(done_cnt - base), WW'(0));

        // Three vectors, empty obstacle map
        pulse_start(16'd3);
        send_beat(v0, "s1_beat0");
        send_beat(v1, "s1_beat1");
        send_beat(v2, "s1_beat2");
        wait_done(200, "s1_done_once");
        check("s1_beats", WW'(beats), WW'(3));
        check("s1_start_to_ready", WW'(first_ready_cyc - start_cyc), WW'(2));
        check("s1_beat_to_rd", WW'(first_rd_cyc - last_beat_cyc), WW'(2));
        check("s1_collide", WW'(collide_at_done), WW'(0));
        check_scan(v0 | v1 | v2, 32'h0, "s1");
        w = 256'h1 << 44;
        check("s1_word1_bit44", res_data[1], w);
        w = 256'h1 << 255;
        check("s1_word31_bit255", res_data[31], w);
        check("s1_word0_bit0", res_data[0], 256'h1);

        // Same vectors, obstacle on word 1 bit 44
        obst_mem[1] = 256'h1 << 44;
        pulse_start(16'd3);
        send_beat(v0, "s2_beat0");
        send_beat(v1, "s2_beat1");
        send_beat(v2, "s2_beat2");
        wait_done(200, "s2_done_once");
        check("s2_collide_at_done", WW'(collide_at_done), WW'(1));
        check_scan(v0 | v1 | v2, 32'h0000_0002, "s2");
        repeat (5) tick();
        check("s2_collide_held", WW'(bus.collide), WW'(1));

        // Zero grids: straight to SETTLE, full scan of a cleared accumulator
        pulse_start(16'd0);
        @(negedge CLK);
        check("s3_collide_cleared", WW'(bus.collide), WW'(0));
        wait_done(200, "s3_done_once");
        check("s3_no_ready", WW'(first_ready_cyc), WW'(-1));
        check("s3_start_to_rd", WW'(first_rd_cyc - start_cyc), WW'(3));
        // Counting the start cycle itself as cycle 1.
        check("s3_start_to_done", WW'(done_cyc - start_cyc + 1), WW'(3 + 3 * NW + 1));
        check("s3_collide", WW'(collide_at_done), WW'(0));
        check_scan('0, 32'h0, "s3");

        // Gapped valid: 1,0,0,1,1 then a 4th offer that must be refused
        pat     = 6'b111001;
        exp_rdy = 6'b011111;
        for (int k = 0; k < 6; k++) begin
            d[k] = '0;
            d[k][k * 1500 + 3] = 1'b1;
        end
        pulse_start(16'd3);
        tick();
        for (int k = 0; k < 6; k++) begin
            bus.grid_in_valid = pat[k];
            bus.grid_in_data  = d[k];
            @(negedge CLK);
            check($sformatf("s4_ready%0d", k), WW'(bus.grid_in_ready), WW'(exp_rdy[k]));
            check($sformatf("s4_unit_grid%0d", k),
                  WW'(bus.unit_grid == ((pat[k] && exp_rdy[k]) ? d[k] : '0)), WW'(1));
            tick();
        end
        bus.grid_in_valid = 1'b0;
        wait_done(200, "s4_done_once");
        check("s4_beats", WW'(beats), WW'(3));
        check_scan(d[0] | d[3] | d[4], 32'h0, "s4");

        // Sink stall at idx 5 with start pulses during the stall
        obst_mem[5] = 256'h1 << 17;
        vs = '0; vs[5 * 256 + 17] = 1'b1;
        pulse_start(16'd1);
        send_beat(vs, "s5_beat0");
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (bus.out_valid && bus.out_idx == 5'd4) begin
                ok = 1'b1;
                break;
            end
        end
        check("s5_reach_idx4", WW'(ok), WW'(1));
        tick();
        bus.out_ready = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLK);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("s5_reach_idx5", WW'(ok), WW'(1));
        w = 256'h1 << 17;
        for (int s = 0; s < 10; s++) begin
            check($sformatf("s5_valid%0d", s), WW'(bus.out_valid), WW'(1));
            check($sformatf("s5_idx%0d", s), WW'(bus.out_idx), WW'(5));
            check($sformatf("s5_data%0d", s), bus.out_data, w);
            check($sformatf("s5_hit%0d", s), WW'(bus.out_hit), WW'(1));
            check($sformatf("s5_no_rd%0d", s), WW'(bus.obst_rd), WW'(0));
            check($sformatf("s5_busy%0d", s), WW'(bus.busy), WW'(1));
            tick();
            bus.start     = (s % 2 == 0);
            bus.num_grids = 16'd7;
            @(negedge CLK);
        end
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        wait_done(200, "s5_done_once");
        check("s5_collide", WW'(collide_at_done), WW'(1));
        check_scan(vs, 32'h0000_0020, "s5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
